// File: rtl/edf_scheduler_pkg.sv
// Shared defaults, mode encoding and id-width helper for the EDF scheduler.
package edf_scheduler_pkg;

   localparam int unsigned NQ_DEF = 4;
   localparam int unsigned W_DEF  = 32;

   localparam logic MODE_EDF = 1'b0;
   localparam logic MODE_FP  = 1'b1;

   // Width of a queue index; never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/edf_scheduler_if.sv
// Queue status, deadline/period configuration and selection outputs of the scheduler.
interface edf_scheduler_if #(
   parameter int unsigned NQ = edf_scheduler_pkg::NQ_DEF,
   parameter int unsigned W  = edf_scheduler_pkg::W_DEF
);
   localparam int unsigned IW = edf_scheduler_pkg::id_width(NQ);

   logic                   mode;
   logic [NQ-1:0]          full;
   logic [NQ-1:0]          empty;
   logic [NQ-1:0]          lastElem;
   logic [NQ-1:0][W-1:0]   deadlines;
   logic [NQ-1:0][W-1:0]   periods;
   logic                   consumed;
   logic [IW-1:0]          id;
   logic [NQ-1:0]          hasBeenConsumed;
   logic                   enable;

   modport master (
      output mode, full, empty, lastElem, deadlines, periods, consumed,
      input  id, hasBeenConsumed, enable
   );

   modport slave (
      input  mode, full, empty, lastElem, deadlines, periods, consumed,
      output id, hasBeenConsumed, enable
   );

endinterface

// File: rtl/edf_min_select.sv
// Combinational argmin over masked keys; ties resolve to the lowest index.
module edf_min_select
   import edf_scheduler_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned KW = 33,
   localparam int unsigned IW = id_width(N)
) (
   input  logic [N-1:0][KW-1:0] keys_i,
   input  logic [N-1:0]         mask_i,
   output logic [IW-1:0]        idx_o,
   output logic                 found_o
);

   logic [KW-1:0] best;
   logic [IW-1:0] idx;
   logic          found;

   // Linear scan; strict less-than keeps the earlier index on equal keys.
   always_comb begin
      best  = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (mask_i[i] && (!found || keys_i[i] < best)) begin
            best  = keys_i[i];
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

   assign idx_o   = idx;
   assign found_o = found;

endmodule

// File: rtl/edf_scheduler.sv
// Earliest-deadline-first queue arbiter with full-queue override and fixed-priority mode.
module edf_scheduler
   import edf_scheduler_pkg::*;
#(
   parameter int unsigned NQ            = NQ_DEF,
   parameter int unsigned W             = W_DEF,
   parameter bit          FULL_OVERRIDE = 1'b1,
   parameter bit          LAST_AWARE    = 1'b1
) (
   input  logic           clock,
   input  logic           reset,
   edf_scheduler_if.slave bus
);

   localparam int unsigned IW = id_width(NQ);
   localparam int unsigned KW = W + 1;

   logic [NQ-1:0][W-1:0]  rem_q, rem_d;
   logic [IW-1:0]         id_q, id_d;
   logic                  enable_q, enable_d;
   logic [NQ-1:0]         hbc_q, hbc_d;

   logic                  cons;
   logic [NQ-1:0]         elig;
   logic [NQ-1:0]         full_hit;
   logic [NQ-1:0][KW-1:0] keys;
   logic [IW-1:0]         edf_idx;
   logic                  edf_found;
   logic [IW-1:0]         full_idx;
   logic [IW-1:0]         fp_idx;
   logic [IW-1:0]         winner;

   // A consume pulse only counts while the current selection is valid.
   assign cons = bus.consumed & enable_q;

   // Eligibility mask and widened EDF keys (one extra bit so the sum never wraps).
   always_comb begin
      elig     = '0;
      keys     = '0;
      for (int i = 0; i < int'(NQ); i++) begin
         elig[i] = ~bus.empty[i];
         if (LAST_AWARE && cons && (id_q == IW'(i)) && bus.lastElem[i]) begin
            elig[i] = 1'b0;
         end
         keys[i] = {1'b0, rem_q[i]} + {1'b0, bus.deadlines[i]};
      end
      full_hit = bus.full & elig;
   end

   edf_min_select #(
      .N  (NQ),
      .KW (KW)
   ) u_min_select (
      .keys_i  (keys),
      .mask_i  (elig),
      .idx_o   (edf_idx),
      .found_o (edf_found)
   );

   // Lowest-index pick for the full override and fixed-priority mode.
   always_comb begin
      full_idx = '0;
      fp_idx   = '0;
      for (int i = int'(NQ) - 1; i >= 0; i--) begin
         if (full_hit[i]) full_idx = IW'(i);
         if (elig[i])     fp_idx   = IW'(i);
      end
   end

   // Winner selection: full override, then fixed priority, then EDF.
   always_comb begin
      winner = id_q;
      if (FULL_OVERRIDE && (|full_hit)) begin
         winner = full_idx;
      end else if (bus.mode == MODE_FP) begin
         winner = fp_idx;
      end else if (edf_found) begin
         winner = edf_idx;
      end
   end

   // Next-state for counters, selection and consume echo.
   always_comb begin
      rem_d    = rem_q;
      enable_d = |elig;
      id_d     = enable_d ? winner : id_q;
      hbc_d    = '0;
      for (int i = 0; i < int'(NQ); i++) begin
         if (cons && (id_q == IW'(i))) begin
            rem_d[i] = bus.periods[i];
         end else if (rem_q[i] != '0) begin
            rem_d[i] = rem_q[i] - W'(1);
         end else begin
            rem_d[i] = '0;
         end
      end
      if (cons) hbc_d[id_q] = 1'b1;
   end

   // State registers; reset leaves every queue maximally urgent.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rem_q    <= '0;
         id_q     <= '0;
         enable_q <= 1'b0;
         hbc_q    <= '0;
      end else begin
         rem_q    <= rem_d;
         id_q     <= id_d;
         enable_q <= enable_d;
         hbc_q    <= hbc_d;
      end
   end

   assign bus.id              = id_q;
   assign bus.enable          = enable_q;
   assign bus.hasBeenConsumed = hbc_q;

endmodule

// File: tb/tb_edf_scheduler.sv
// Scoreboard bench for edf_scheduler: stimulus queues expectations, a negedge monitor checks them.
module tb_edf_scheduler;
   import edf_scheduler_pkg::*;

   localparam int unsigned NQ = 4;
   localparam int unsigned W  = 32;

   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   edf_scheduler_if #(.NQ(NQ), .W(W)) bus ();

   edf_scheduler #(
      .NQ            (NQ),
      .W             (W),
      .FULL_OVERRIDE (1'b1),
      .LAST_AWARE    (1'b1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // chk bit 0: id, bit 1: enable, bit 2: hasBeenConsumed
   typedef struct {
      int         cyc;
      string      name;
      logic [1:0] id;
      logic       en;
      logic [3:0] hbc;
      logic [2:0] chk;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   // Cycle index used to tag when an expectation becomes observable.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic cmp(input string name, input string field, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
      end
   endtask

   task automatic check_exp(input exp_t e);
      if (e.chk[0]) cmp(e.name, "id", int'(bus.id), int'(e.id));
      if (e.chk[1]) cmp(e.name, "enable", int'(bus.enable), int'(e.en));
      if (e.chk[2]) cmp(e.name, "hasBeenConsumed", int'(bus.hasBeenConsumed), int'(e.hbc));
   endtask

   // Monitor: pops every expectation due by the current cycle, away from the rising edge.
   always @(negedge clock) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         check_exp(exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_at(input int dly, input string name, input logic [1:0] id,
                            input logic en, input logic [3:0] hbc);
      exp_t e;
      e.cyc  = cyc + dly;
      e.name = name;
      e.id   = id;
      e.en   = en;
      e.hbc  = hbc;
      e.chk  = 3'b111;
      exp_q.push_back(e);
   endtask

   task automatic set_dl(input int d0, input int d1, input int d2, input int d3);
      bus.deadlines[0] = W'(d0);
      bus.deadlines[1] = W'(d1);
      bus.deadlines[2] = W'(d2);
      bus.deadlines[3] = W'(d3);
   endtask

   initial begin
      bus.mode     = MODE_EDF;
      bus.full     = '0;
      bus.empty    = '0;
      bus.lastElem = '0;
      bus.consumed = 1'b0;
      set_dl(0, 0, 0, 0);
      for (int i = 0; i < int'(NQ); i++) bus.periods[i] = W'(16);

      tick(); tick();
      expect_at(0, "reset", 2'd0, 1'b0, 4'b0000);

      tick(); reset = 1'b1;
      expect_at(1, "release", 2'd0, 1'b1, 4'b0000);

      tick(); bus.consumed = 1'b1;
      expect_at(1, "consume0", 2'd0, 1'b1, 4'b0001);

      tick(); bus.consumed = 1'b0;
      expect_at(1, "pulse_end", 2'd1, 1'b1, 4'b0000);

      tick(); bus.empty = 4'b1111;
      expect_at(1, "all_empty", 2'd1, 1'b0, 4'b0000);

      tick(); bus.consumed = 1'b1;
      expect_at(1, "ign_consume", 2'd1, 1'b0, 4'b0000);

      tick(); bus.consumed = 1'b0; bus.empty = 4'b0000; bus.full = 4'b0100;
      set_dl(0, 100, 100, 100);
      expect_at(1, "full_ovr", 2'd2, 1'b1, 4'b0000);

      tick(); bus.full = 4'b0000;
      expect_at(1, "full_clr", 2'd0, 1'b1, 4'b0000);

      tick(); bus.mode = MODE_FP; bus.empty = 4'b0001;
      expect_at(1, "fixed_pri", 2'd1, 1'b1, 4'b0000);

      tick(); bus.mode = MODE_EDF; bus.empty = 4'b0000;
      set_dl(5, 1, 9, 9);
      expect_at(1, "edf_min", 2'd1, 1'b1, 4'b0000);

      tick(); set_dl(20, 8, 3, 3);
      expect_at(1, "edf_tie", 2'd2, 1'b1, 4'b0000);

      tick(); set_dl(20, 8, 5, 2);
      expect_at(1, "edf_q3", 2'd3, 1'b1, 4'b0000);

      tick(); bus.lastElem = 4'b1000; bus.consumed = 1'b1;
      expect_at(1, "last_excl", 2'd2, 1'b1, 4'b1000);

      tick(); bus.lastElem = 4'b0000; bus.consumed = 1'b0;
      expect_at(1, "reload3", 2'd2, 1'b1, 4'b0000);

      tick(); bus.full = 4'b0001; bus.empty = 4'b0001;
      expect_at(1, "full_empty", 2'd2, 1'b1, 4'b0000);

      tick(); bus.full = 4'b0110; bus.empty = 4'b0000;
      expect_at(1, "multi_full", 2'd1, 1'b1, 4'b0000);

      tick(); bus.consumed = 1'b1;
      expect_at(1, "consume1", 2'd1, 1'b1, 4'b0010);

      tick(); bus.consumed = 1'b0;
      // Assert reset between edges; outputs must clear before the next rising edge.
      @(negedge clock); #1;
      reset = 1'b0;
      #1;
      cmp("async_rst", "id", int'(bus.id), 0);
      cmp("async_rst", "enable", int'(bus.enable), 0);
      cmp("async_rst", "hasBeenConsumed", int'(bus.hasBeenConsumed), 0);

      bus.full = 4'b0000;
      tick(); tick(); reset = 1'b1;
      expect_at(1, "re_release", 2'd3, 1'b1, 4'b0000);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/edf_scheduler.md
Name: edf_scheduler

Overview:
- Earliest-deadline-first arbiter selecting which of NQ request queues the downstream memory port serves next.
- Sits between the per-queue FIFOs (which supply full/empty/lastElem status) and the output mux/consumer (which pulses consumed).
- Keeps one remaining-time counter per queue and registers the selected queue id plus a valid flag every cycle.
- Full queues pre-empt deadline ordering.

Parameters:
- NQ, 4, number of queues; id width is IW = clog2(NQ).
- W, 32, width of deadline, period and internal counters.
- FULL_OVERRIDE, 1, when 1 a full queue pre-empts EDF ordering.
- LAST_AWARE, 1, when 1 a consumption with lastElem set excludes that queue from the following decision.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = EDF selection, 1 = fixed priority (lowest non-empty index).
- full  in  NQ  per-queue FIFO full flag.
- empty  in  NQ  per-queue FIFO empty flag.
- lastElem  in  NQ  queue holds exactly one element.
- deadlines  in  NQ x W  per-queue relative deadline offset.
- periods  in  NQ x W  per-queue period (counter reload value).
- id  out  IW  registered selected queue.
- consumed  in  1  one-cycle pulse: head of queue id taken this cycle.
- hasBeenConsumed  out  NQ  registered one-hot echo of the consumed queue.
- enable  out  1  registered; id is valid and its queue is non-empty.

Behaviour:
- Reset (reset=0, async):
  - id=0, enable=0, hasBeenConsumed=0.
  - All remaining[i]=0, i.e. every queue is urgent after reset.
- Counters: each cycle remaining[i] decrements, saturating at 0. If consumed=1 and id==i, remaining[i] loads periods[i] instead.
- EDF key: key[i] = remaining[i] + deadlines[i], computed in W+1 bits so it never wraps.
- Eligibility:
  - elig[i] = !empty[i].
  - If LAST_AWARE and consumed and id==i and lastElem[i], elig[i]=0 for this decision.
- Selection, combinational on current-cycle inputs and counters:
  - If FULL_OVERRIDE and any (full[i] & elig[i]): pick the lowest such index.
  - Else if mode=1: pick the lowest eligible index.
  - Else: pick the eligible i with minimum key; ties go to the lowest index.
- Registering and latency:
  - Selection is registered at the rising edge: next id = winner, next enable = |elig.
  - Latency is one cycle from input change to id/enable.
  - If no queue is eligible: enable<=0 and id holds its previous value.
- hasBeenConsumed: next value = consumed ? onehot(id) : 0. It is a one-cycle pulse, one cycle after consumed.
- consumed while enable=0: ignored. No counter reload, hasBeenConsumed stays 0.
- Simultaneous full on several queues: lowest index wins.
- full and empty both set on one queue is illegal; empty dominates.
- Inputs deadlines/periods may change at any time and take effect at the next computation.
- Reset asserted mid-operation clears everything immediately, with no pending pulse.

Decomposition:
- Shared package: NQ/W defaults, IW function (clog2), mode encoding constants (MODE_EDF=0, MODE_FP=1).
- One natural sub-module: edf_min_select. It is a combinational argmin over NQ keys with an eligibility mask and returns index plus found flag; implement as a tree or linear scan with lowest-index tie-break.
- Counters, override logic and output registers stay in the top module.

Test Plan:
- Reset release with empty=0000, all deadlines 0 -> within one cycle id=0, enable=1, hasBeenConsumed=0000.
- consumed=1 for one cycle with id=0, periods[0]=16 -> next cycle hasBeenConsumed=0001, then 0000. remaining[0]=16, so with other keys at 0 the id moves to 1.
- empty=1111 -> one cycle later enable=0 and id holds its value; a consumed pulse here leaves hasBeenConsumed=0000.
- full=0100, mode=0, queue 0 most urgent -> next cycle id=2, enable=1. Clear full -> id returns to the minimum-key queue.
- mode=1, empty=0001 -> id=1. With deadlines={5,1,9,9}, remaining all 0, mode=0, empty=0 -> id=1. Tie on keys -> lowest index.
- LAST_AWARE: id=3, lastElem[3]=1, consumed=1, empty unchanged -> next id != 3. Also assert reset mid-count -> outputs cleared asynchronously.
